// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines,
// deframes 11-bit frames and delivers raw scancode bytes.
//
// Ports:
//   clk_in     - system clock (50 MHz), all state in this domain
//   reset_n    - asynchronous active-low reset
//   ps2_clock  - raw PS/2 clock line (asynchronous)
//   ps2_data   - raw PS/2 data line (asynchronous)
//   scancode   - last correctly received byte, held until next good frame
//   valid      - one-cycle pulse when scancode is updated
//   parity_err - one-cycle pulse on odd-parity failure
//   frame_err  - one-cycle pulse on bad stop bit or inter-edge timeout
module ps2_scancode_rx #(
    parameter int P_FILTER  = 8,
    parameter int P_TIMEOUT = 50000
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam logic [3:0]    FILT_LIM = 4'(P_FILTER - 1);
    localparam logic [TW-1:0] TMO_LIM  = TW'(P_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          clk_s1;
    logic          clk_s2;
    logic          dat_s1;
    logic          dat_s2;
    logic          filt_clk;
    logic          filt_d;
    logic [3:0]    filt_cnt;

    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;

    logic          fall;
    logic          timeout;
    logic          par_ok;
    logic          valid_nxt;
    logic          parity_nxt;
    logic          frame_nxt;

    // Line synchronizers and clock glitch filter. The filtered level
    // only flips after P_FILTER consecutive samples at the new level;
    // the run counter restarts whenever the sample agrees again.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt_clk <= 1'b1;
            filt_d   <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1 <= ps2_clock;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            filt_d <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LIM) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 4'd1;
            end
        end
    end

    // One-cycle strobe in the cycle the filtered clock has just gone low.
    assign fall = filt_d & ~filt_clk;

    // Counter holds cycles since the edge that was last consumed; the
    // abort fires on the cycle it would reach P_TIMEOUT.
    assign timeout = (state != S_IDLE) && !fall && (tmo_cnt == TMO_LIM);

    // Odd parity: data ones plus the parity bit must be odd.
    assign par_ok = ^{shift, par_bit};

    // State register.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (fall && !dat_s2) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (fall && (bit_cnt == 3'd7)) begin
                    state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                if (fall) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (timeout) begin
            state_nxt = S_IDLE;
        end
    end

    // Output decode: the three events are exclusive by construction,
    // a stop-bit failure takes precedence over a parity failure.
    always_comb begin
        valid_nxt  = 1'b0;
        parity_nxt = 1'b0;
        frame_nxt  = 1'b0;
        if ((state == S_STOP) && fall) begin
            if (!dat_s2) begin
                frame_nxt = 1'b1;
            end else if (par_ok) begin
                valid_nxt = 1'b1;
            end else begin
                parity_nxt = 1'b1;
            end
        end
        if (timeout) begin
            frame_nxt = 1'b1;
        end
    end

    // Frame datapath: shift register, bit counter, parity capture.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            shift   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
        end else if (fall) begin
            unique case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                end
                S_DATA: begin
                    shift   <= {dat_s2, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                S_PARITY: begin
                    par_bit <= dat_s2;
                end
                S_STOP: begin
                    bit_cnt <= '0;
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Inter-edge timeout counter, idle at zero outside a frame.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if ((state == S_IDLE) || fall || timeout) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Registered outputs: pulses appear the cycle after the deciding edge.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            scancode   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid      <= valid_nxt;
            parity_err <= parity_nxt;
            frame_err  <= frame_nxt;
            if (valid_nxt) begin
                scancode <= shift;
            end
        end
    end

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 SHALL have parameter P_FILTER, default 8: consecutive equal synchronized ps2_clock samples needed to change the filtered clock level (range 2..15).
REQ-002 SHALL have parameter P_TIMEOUT, default 50000: clk_in cycles without a filtered falling edge before an in-progress frame is abandoned (1 ms at 50 MHz).
REQ-003 SHALL have port clk_in  input  1  single 50 MHz system clock; all state is in this domain.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clock  input  1  raw PS/2 clock line, asynchronous to clk_in.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk_in.
REQ-007 SHALL have port scancode  output  8  last correctly received byte; holds until the next good frame.
REQ-008 SHALL have port valid  output  1  one-cycle pulse marking a new scancode; no backpressure.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse when a frame fails odd parity.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on stop bit = 0 or timeout.

Function
REQ-011 SHALL pass ps2_clock and ps2_data each through a 2-flop synchronizer before any use.
REQ-012 SHALL hold a filtered clock level (reset 1) that becomes 0 only after P_FILTER consecutive synchronized 0 samples and 1 only after P_FILTER consecutive 1 samples; shorter pulses are ignored.
REQ-013 SHALL define an edge as the cycle the filtered clock goes 1->0 and sample synchronized ps2_data in that same cycle.
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP; reset state IDLE.
REQ-015 IDLE: edge with data 0 -> DATA, bit count 0; edge with data 1 -> stay IDLE, no error.
REQ-016 DATA: each edge shifts in one bit, LSB first; after the 8th bit -> PARITY.
REQ-017 PARITY: edge captures the parity bit -> STOP; odd parity means data ones + parity bit is odd.
REQ-018 STOP: edge -> IDLE; if stop=1 and parity good, scancode updates and valid pulses in the cycle after the edge.
REQ-019 STOP edge with stop=1 and bad parity SHALL pulse parity_err only; stop=0 SHALL pulse frame_err only, whatever the parity; neither updates scancode nor pulses valid.
REQ-020 SHALL count cycles since the last edge while not IDLE; on reaching P_TIMEOUT -> IDLE, frame_err pulses once, partial data is discarded, counter clears.
REQ-021 valid, parity_err and frame_err SHALL be mutually exclusive, and each SHALL stay high for exactly one cycle per event.
REQ-022 SHALL do no make/break (0xF0) or extended (0xE0) interpretation; every byte is delivered raw.
REQ-023 SHALL size the timeout counter for P_TIMEOUT with no wrap before the limit.

Reset
REQ-024 While reset_n = 0: state IDLE, scancode 0x00, valid/parity_err/frame_err 0, synchronizers and filtered clock 1, counters 0.
REQ-025 reset_n asserted mid-frame SHALL discard the frame with no error pulse; after release the next full frame SHALL decode normally.

Verification
REQ-026 Frame 0x5A (parity 1, stop 1), 20 us bit period -> one valid pulse, scancode = 0x5A, no error pulses.
REQ-027 Back-to-back 0xF0 then 0x1C (parity 1, then 0) -> two valid pulses with scancode 0xF0 then 0x1C; scancode holds 0x1C afterward.
REQ-028 Frame 0x5A with parity 0 -> one parity_err pulse, no valid, scancode unchanged; 0x5A with stop 0 -> one frame_err pulse.
REQ-029 Start bit plus 3 data bits, then line idle -> frame_err exactly P_TIMEOUT cycles after the last edge; a following clean 0x45 frame -> valid, scancode 0x45.
REQ-030 3-cycle low glitch on ps2_clock while idle -> no state change, no pulses; reset_n low during bit 4 of a frame -> outputs return to reset values with no error pulse.
